// File: rtl/ema_axis_if.sv
// AXI-Stream style handshake bundle used on both sides of ema_axis.
// The tlast wire exists only when EMA_TLAST_EN is defined.
interface ema_axis_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
`ifdef EMA_TLAST_EN
  logic              tlast;
`endif

`ifdef EMA_TLAST_EN
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/ema_axis.sv
// Streaming exponential moving average: y <= x/4 + y/4 + y/2, one sample per cycle.
// Define EMA_TLAST_EN to add tlast pass-through and per-packet filter restart.
module ema_axis #(
  parameter int unsigned         DATA_W   = 32,
  parameter logic [DATA_W-1:0]   INIT_VAL = DATA_W'(32'h000003E8)
) (
  input  logic        clk,
  input  logic        rst,
  ema_axis_if.slave   s_axis,
  ema_axis_if.master  m_axis,
  output logic [15:0] sample_cnt
);

  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] y_next;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              in_fire;
  logic              out_fire;
`ifdef EMA_TLAST_EN
  logic              out_last;
`endif

  // A new sample is accepted whenever the output slot is empty or being drained.
  assign s_axis.tready = ~out_valid | m_axis.tready;
  assign in_fire       = s_axis.tvalid & s_axis.tready;
  assign out_fire      = out_valid & m_axis.tready;

  // Each term is shifted on its own; the sum cannot carry past DATA_W bits,
  // so dropping the extra carry bit leaves the result unchanged.
  always_comb begin
    y_next = (s_axis.tdata >> 2) + (y >> 2) + (y >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y          <= INIT_VAL;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sample_cnt <= 16'h0000;
`ifdef EMA_TLAST_EN
      out_last   <= 1'b0;
`endif
    end else begin
      if (in_fire) begin
        out_data  <= y_next;
        out_valid <= 1'b1;
`ifdef EMA_TLAST_EN
        out_last  <= s_axis.tlast;
        y         <= s_axis.tlast ? INIT_VAL : y_next;
`else
        y         <= y_next;
`endif
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) begin
        sample_cnt <= sample_cnt + 16'h0001;
      end
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
`ifdef EMA_TLAST_EN
  assign m_axis.tlast  = out_last;
`endif

endmodule

// File: doc/ema_axis.md
EMA_AXIS -- requirements
Module: ema_axis

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the sample width in bits.
REQ-002 The block SHALL have parameter INIT_VAL, default 32'h000003E8, giving the filter state after reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; reset is asynchronous and active-high.
REQ-005 The block SHALL have port s_axis_tdata, input, DATA_W bits, the input sample (unsigned).
REQ-006 The block SHALL have port s_axis_tvalid, input, 1 bit, input sample valid.
REQ-007 The block SHALL have port s_axis_tready, output, 1 bit, block can accept an input sample.
REQ-008 The block SHALL have port m_axis_tdata, output, DATA_W bits, the filtered sample (unsigned).
REQ-009 The block SHALL have port m_axis_tvalid, output, 1 bit, output sample valid.
REQ-010 The block SHALL have port m_axis_tready, input, 1 bit, downstream accepts the output sample.
REQ-011 The block SHALL have port sample_cnt, output, 16 bits, count of output samples accepted downstream.

Function
REQ-012 An input transfer SHALL occur on any rising edge where s_axis_tvalid and s_axis_tready are both high.
REQ-013 An output transfer SHALL occur on any rising edge where m_axis_tvalid and m_axis_tready are both high.
REQ-014 s_axis_tready SHALL equal (not m_axis_tvalid) or m_axis_tready, as a combinational signal.
REQ-015 State register y SHALL hold the most recent computed output and SHALL equal INIT_VAL before the first output.
REQ-016 On an input transfer of x, the block SHALL load y and m_axis_tdata with (x>>2)+(y>>2)+(y>>1).
REQ-017 The REQ-016 sum SHALL be formed at DATA_W+1 bits and truncated to DATA_W bits; each shift truncates independently.
REQ-018 On an input transfer, m_axis_tvalid SHALL be set on the same edge, giving 1-cycle latency from input transfer to output valid.
REQ-019 The block SHALL sustain one sample per cycle while m_axis_tready is held high.
REQ-020 On an output transfer with no input transfer on that edge, m_axis_tvalid SHALL clear.
REQ-021 On an output transfer and an input transfer on the same edge, m_axis_tvalid SHALL stay high and the new sample SHALL replace the old one.
REQ-022 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata SHALL hold stable and y SHALL not change.
REQ-023 Input samples SHALL never be dropped or duplicated.
REQ-024 sample_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-025 Asserting rst SHALL immediately force y=INIT_VAL, m_axis_tdata=0, m_axis_tvalid=0 and sample_cnt=0, including mid-stream and with a pending output.
REQ-026 During reset, s_axis_tready SHALL read 1 through REQ-014, but no transfer SHALL be registered while rst is high.
REQ-027 The first input transfer after rst deasserts SHALL use y=INIT_VAL.

Configuration
REQ-028 Macro EMA_TLAST_EN SHALL control packet support.
REQ-029 With EMA_TLAST_EN defined, the block SHALL add input s_axis_tlast and output m_axis_tlast, each 1 bit.
REQ-030 With EMA_TLAST_EN defined, m_axis_tlast SHALL be registered alongside m_axis_tdata and SHALL reset to 0.
REQ-031 With EMA_TLAST_EN defined, an input transfer with s_axis_tlast=1 SHALL produce its output normally, after which y SHALL reload INIT_VAL on the same edge.
REQ-032 Without EMA_TLAST_EN, the tlast ports SHALL not exist and y SHALL never reload except on reset.

Verification
REQ-033 After reset, send 0x64 then 0xC8 with m_axis_tready=1 -> outputs 0x307 then 0x276, each 1 cycle after its input transfer, and sample_cnt=2.
REQ-034 Hold m_axis_tready=0, send 0x64, then offer 0xC8 -> m_axis_tdata holds 0x307 and s_axis_tready=0; release tready -> 0x307 then 0x276 are output, each exactly once.
REQ-035 Drive back-to-back inputs 100..1500 in steps of 100 with tvalid and tready high -> one output per cycle, each matching (x>>2)+(y>>2)+(y>>1) from y=0x3E8.
REQ-036 Assert rst for one cycle while output 0x307 is pending -> m_axis_tvalid=0 and sample_cnt=0; next input 0x64 -> 0x307.
REQ-037 With EMA_TLAST_EN: send 0x64 with tlast=1, then 0x64 -> outputs 0x307 (tlast=1) then 0x307. Without the macro: same inputs -> 0x307 then 0x25D.
REQ-038 Force sample_cnt to 16'hFFFF (via 65535 transfers), then one more output transfer -> sample_cnt=0.
